// File: rtl/mult_scaler_pipe.sv
// mult_scaler_pipe
//   Two-stage pipelined per-lane multiply, scale and saturate.
//   S1 holds the full signed product of each feature lane with a shared
//   scaler, together with that transaction's shift/round/sat controls.
//   S2 holds the rounded, arithmetically shifted and saturated (or wrapped)
//   result per lane. Out-of-range lanes set a sticky per-lane flag.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake; in_ready = !out_valid || out_ready
//   in_feature            CHANNELS signed lanes, lane k at [k*FW +: FW]
//   in_scaler             signed scaler shared by all lanes
//   in_shift              arithmetic right-shift amount
//   in_round              round-half-up enable
//   in_sat                saturate (1) or wrap (0)
//   out_valid / out_ready output handshake
//   out_data              CHANNELS signed results, same packing as in_feature
//   ovf_sticky            per-lane sticky out-of-range flag
//   ovf_clr               synchronous clear of ovf_sticky (a same-cycle set wins)
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid and payload hold unchanged until that transfer occurs.
module mult_scaler_pipe #(
    parameter int FEATURE_WIDTH = 32,
    parameter int SCALER_WIDTH  = 32,
    parameter int CHANNELS      = 4,
    parameter int SHIFT_WIDTH   = 6
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [CHANNELS*FEATURE_WIDTH-1:0] in_feature,
    input  logic [SCALER_WIDTH-1:0]           in_scaler,
    input  logic [SHIFT_WIDTH-1:0]            in_shift,
    input  logic                              in_round,
    input  logic                              in_sat,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [CHANNELS*FEATURE_WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]               ovf_sticky,
    input  logic                              ovf_clr
);

    localparam int FW = FEATURE_WIDTH;
    localparam int SW = SCALER_WIDTH;
    localparam int CH = CHANNELS;
    localparam int PW = FW + SW;
    localparam logic [31:0] MAX_SHIFT = 32'(PW - 1);

    // Whole pipeline moves together whenever the output slot is free or draining.
    logic adv;

    // Stage 1 registers
    logic                   s1_valid_q, s1_valid_d;
    logic signed [PW-1:0]   prod_q [CH];
    logic signed [PW-1:0]   prod_d [CH];
    logic [SHIFT_WIDTH-1:0] shift_q, shift_d;
    logic                   round_q, round_d;
    logic                   sat_q, sat_d;

    // Stage 2 registers
    logic                   out_valid_q, out_valid_d;
    logic [CH*FW-1:0]       out_data_q, out_data_d;
    logic [CH-1:0]          ovf_q, ovf_d;

    // Stage 2 combinational intermediates
    logic [31:0]            s_eff;
    logic signed [PW:0]     rnd_add;
    logic signed [PW:0]     ext [CH];
    logic signed [PW:0]     sh_v [CH];
    logic [FW-1:0]          lane_res [CH];
    logic [CH-1:0]          lane_ovf;

    // ---------------------------------------------------------------- stage 1
    always_comb begin
        adv        = !out_valid_q || out_ready;
        s1_valid_d = s1_valid_q;
        prod_d     = prod_q;
        shift_d    = shift_q;
        round_d    = round_q;
        sat_d      = sat_q;
        if (adv) begin
            // A cycle without an accepted input pushes a bubble into S1.
            s1_valid_d = in_valid;
            if (in_valid) begin
                for (int k = 0; k < CH; k++) begin
                    // Both operands sign-extended to the full product width so
                    // the signed product never wraps.
                    prod_d[k] = PW'($signed(in_feature[k*FW +: FW])) * PW'($signed(in_scaler));
                end
                shift_d = in_shift;
                round_d = in_round;
                sat_d   = in_sat;
            end
        end
    end

    // ---------------------------------------------------------------- stage 2
    always_comb begin
        // Shifting past the product's sign bit gives nothing new, so clamp.
        s_eff   = (32'(shift_q) > MAX_SHIFT) ? MAX_SHIFT : 32'(shift_q);
        rnd_add = '0;
        if (round_q && (s_eff != 32'd0)) begin
            rnd_add = (PW+1)'(1) << (s_eff - 32'd1);
        end

        for (int k = 0; k < CH; k++) begin
            // One extra bit of headroom so the rounding add cannot wrap.
            ext[k]  = (PW+1)'(prod_q[k]) + rnd_add;
            sh_v[k] = ext[k] >>> s_eff;
            // In range iff every bit from FW-1 upward is a copy of the sign.
            lane_ovf[k] = !((&sh_v[k][PW:FW-1]) || !(|sh_v[k][PW:FW-1]));
            if (lane_ovf[k] && sat_q) begin
                lane_res[k] = sh_v[k][PW] ? {1'b1, {(FW-1){1'b0}}} : {1'b0, {(FW-1){1'b1}}};
            end else begin
                lane_res[k] = sh_v[k][FW-1:0];
            end
        end

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        ovf_d       = ovf_clr ? '0 : ovf_q;
        if (adv) begin
            out_valid_d = s1_valid_q;
            // Bubbles leave the data and the sticky flags untouched.
            if (s1_valid_q) begin
                for (int k = 0; k < CH; k++) begin
                    out_data_d[k*FW +: FW] = lane_res[k];
                end
                ovf_d = ovf_d | lane_ovf;
            end
        end
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            for (int k = 0; k < CH; k++) begin
                prod_q[k] <= '0;
            end
            shift_q     <= '0;
            round_q     <= 1'b0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ovf_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            for (int k = 0; k < CH; k++) begin
                prod_q[k] <= prod_d[k];
            end
            shift_q     <= shift_d;
            round_q     <= round_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready   = adv;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_mult_scaler_pipe.sv
// tb_mult_scaler_pipe
//   Bench for mult_scaler_pipe with FW=32, SW=32, CH=4, SHIFT_WIDTH=6.
//   Reference results come from wide-integer arithmetic on each accepted input;
//   the expected sticky flags are derived from when each result first appears.
module tb_mult_scaler_pipe;

    localparam logic signed [127:0] MAXV = 128'sd2147483647;
    localparam logic signed [127:0] MINV = -128'sd2147483648;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_feature;
    logic [31:0]  in_scaler;
    logic [5:0]   in_shift;
    logic         in_round;
    logic         in_sat;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [3:0]   ovf_sticky;
    logic         ovf_clr;

    int total = 0;
    int bad   = 0;

    // Expected results: {ovf[3:0], data[127:0]}
    logic [131:0] exp_q[$];
    logic [3:0]   sticky_exp;
    logic         prev_valid, prev_hs, clr_prev;
    logic [127:0] last_data;

    mult_scaler_pipe #(
        .FEATURE_WIDTH(32),
        .SCALER_WIDTH (32),
        .CHANNELS     (4),
        .SHIFT_WIDTH  (6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_feature(in_feature),
        .in_scaler (in_scaler),
        .in_shift  (in_shift),
        .in_round  (in_round),
        .in_sat    (in_sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .ovf_sticky(ovf_sticky),
        .ovf_clr   (ovf_clr)
    );

    // ------------------------------------------------------------ clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------ helpers
    function automatic void chk(input string nm, input logic [131:0] act, input logic [131:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endfunction

    function automatic logic [127:0] pack4(input logic [31:0] a0, input logic [31:0] a1,
                                           input logic [31:0] a2, input logic [31:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    // Reference: exact product, optional +2^(s-1), floor-divide by 2^s, then
    // clip or wrap to 32 bits.
    function automatic void model(input logic [127:0] f, input logic [31:0] sc,
                                  input logic [5:0] sh, input logic r, input logic s,
                                  output logic [127:0] d, output logic [3:0] o);
        logic signed [127:0] p;
        logic signed [127:0] q;
        logic signed [127:0] v;
        int e;
        e = (int'(sh) > 63) ? 63 : int'(sh);
        d = '0;
        o = '0;
        for (int k = 0; k < 4; k++) begin
            p = $signed(f[k*32 +: 32]);
            q = $signed(sc);
            p = p * q;
            if (r && e > 0) p = p + (128'sd1 <<< (e - 1));
            v = p >>> e;
            o[k] = (v > MAXV) || (v < MINV);
            if (o[k] && s) d[k*32 +: 32] = (v < 0) ? 32'h8000_0000 : 32'h7fff_ffff;
            else           d[k*32 +: 32] = v[31:0];
        end
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 3))
            0:       return $urandom();
            1:       return 32'($urandom_range(0, 2000)) - 32'd1000;
            2:       return $urandom_range(0, 1) ? 32'h4000_0000 : 32'hc000_0000;
            default: return 32'($urandom_range(0, 70000)) - 32'd35000;
        endcase
    endfunction

    // ------------------------------------------------------------ scoreboard
    always @(negedge clk) begin
        logic fresh;
        logic hs;
        logic [127:0] md;
        logic [3:0]   mo;
        if (!rst_n) begin
            chk("rst_out_valid", 132'(out_valid), 132'd0);
            chk("rst_out_data", 132'(out_data), 132'd0);
            chk("rst_ovf", 132'(ovf_sticky), 132'd0);
            chk("rst_in_ready", 132'(in_ready), 132'd1);
            exp_q.delete();
            sticky_exp = '0;
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
            clr_prev   = 1'b0;
            last_data  = '0;
        end else begin
            fresh = out_valid && (!prev_valid || prev_hs);
            if (clr_prev) sticky_exp = '0;
            if (fresh) begin
                if (exp_q.size() == 0) chk("unexpected_out_valid", 132'd1, 132'd0);
                else sticky_exp = sticky_exp | exp_q[0][131:128];
            end
            if (out_valid && exp_q.size() > 0) chk("out_data", 132'(out_data), 132'(exp_q[0][127:0]));
            if (out_valid && !fresh) chk("stall_stable", 132'(out_data), 132'(last_data));
            chk("ovf_sticky", 132'(ovf_sticky), 132'(sticky_exp));
            chk("in_ready_rule", 132'(in_ready), 132'(!out_valid || out_ready));
            if (in_valid && in_ready) begin
                model(in_feature, in_scaler, in_shift, in_round, in_sat, md, mo);
                exp_q.push_back({mo, md});
            end
            hs = out_valid && out_ready;
            if (hs && exp_q.size() > 0) void'(exp_q.pop_front());
            prev_valid = out_valid;
            prev_hs    = hs;
            clr_prev   = ovf_clr;
            last_data  = out_data;
        end
    end

    // ------------------------------------------------------------ driver tasks
    // All tasks start and end just after a rising edge.
    task automatic one_shot(input string nm, input logic [127:0] f, input logic [31:0] sc,
                            input logic [5:0] sh, input logic r, input logic s,
                            input logic clr_at_load, input logic [127:0] exp_d,
                            input logic [3:0] exp_st);
        in_valid = 1'b1; in_feature = f; in_scaler = sc; in_shift = sh;
        in_round = r; in_sat = s;
        @(posedge clk); #1;
        in_valid = 1'b0;
        ovf_clr  = clr_at_load;
        @(negedge clk);
        chk({nm, "_early"}, 132'(out_valid), 132'd0);
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        @(negedge clk);
        chk({nm, "_valid"}, 132'(out_valid), 132'd1);
        chk({nm, "_data"}, 132'(out_data), 132'(exp_d));
        chk({nm, "_sticky"}, 132'(ovf_sticky), 132'(exp_st));
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [127:0] f, input logic [31:0] sc, input logic [5:0] sh,
                        input logic r, input logic s);
        logic acc;
        int n;
        in_valid = 1'b1; in_feature = f; in_scaler = sc; in_shift = sh;
        in_round = r; in_sat = s;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!acc) chk("send_timeout", 132'd0, 132'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() > 0) chk("drain_timeout", 132'd0, 132'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        logic [127:0] md;
        logic [3:0]   mo;
        logic [127:0] held;
        rst_n = 1'b0; in_valid = 1'b0; in_feature = '0; in_scaler = '0; in_shift = '0;
        in_round = 1'b0; in_sat = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;

        // Pin the reference model to hand-computed values.
        model(pack4(1000, -1000, 3, 0), 32'd2048, 6'd10, 1'b0, 1'b1, md, mo);
        chk("model_basic", {mo, md}, {4'b0, pack4(2000, -2000, 6, 0)});
        model(pack4(3, -3, 0, 0), 32'd1, 6'd1, 1'b1, 1'b1, md, mo);
        chk("model_round", {mo, md}, {4'b0, pack4(2, -1, 0, 0)});
        model(pack4(32'h4000_0000, 0, 32'hc000_0000, 0), 32'd4, 6'd0, 1'b0, 1'b0, md, mo);
        chk("model_wrap", {mo, md}, {4'b0101, pack4(0, 0, 0, 0)});

        repeat (3) @(negedge clk);
        chk("reset_in_ready", 132'(in_ready), 132'd1);
        chk("reset_out_valid", 132'(out_valid), 132'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        one_shot("basic", pack4(1000, -1000, 3, 0), 32'd2048, 6'd10, 1'b0, 1'b1, 1'b0,
                 pack4(2000, -2000, 6, 0), 4'b0000);
        one_shot("round1", pack4(3, -3, 0, 0), 32'd1, 6'd1, 1'b1, 1'b1, 1'b0,
                 pack4(2, -1, 0, 0), 4'b0000);
        one_shot("round0", pack4(3, -3, 0, 0), 32'd1, 6'd1, 1'b0, 1'b1, 1'b0,
                 pack4(1, -2, 0, 0), 4'b0000);
        one_shot("clamp", pack4(-1, 1, 0, 0), 32'd1, 6'd63, 1'b0, 1'b1, 1'b0,
                 pack4(-1, 0, 0, 0), 4'b0000);
        one_shot("sat1", pack4(32'h4000_0000, 5, 32'hc000_0000, 0), 32'd4, 6'd0, 1'b0, 1'b1, 1'b0,
                 pack4(32'h7fff_ffff, 20, 32'h8000_0000, 0), 4'b0101);
        one_shot("sat0", pack4(32'h4000_0000, 5, 0, 0), 32'd4, 6'd0, 1'b0, 1'b0, 1'b0,
                 pack4(0, 20, 0, 0), 4'b0101);

        // Clear pulse with no overflow alongside it.
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        @(negedge clk);
        chk("clr_sticky", 132'(ovf_sticky), 132'd0);
        @(posedge clk); #1;

        // Clear on the same edge an overflowing lane loads: the set wins.
        one_shot("clr_vs_set", pack4(0, 0, 0, 32'h4000_0000), 32'd4, 6'd0, 1'b0, 1'b1, 1'b1,
                 pack4(0, 0, 0, 32'h7fff_ffff), 4'b1000);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;

        // Backpressure: five back-to-back inputs, three-cycle stall.
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    send(pack4(100 + i, -(i + 1), i * 7, 32'h4000_0000), 32'd3 + 32'(i), 6'(i), 1'b1, 1'(i % 2));
                end
            end
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (!out_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                if (!out_valid) chk("bp_wait_timeout", 132'd0, 132'd1);
                @(posedge clk); #1;
                out_ready = 1'b0;
                @(negedge clk);
                held = out_data;
                for (int i = 0; i < 3; i++) begin
                    if (i > 0) @(negedge clk);
                    chk("bp_in_ready", 132'(in_ready), 132'd0);
                    chk("bp_valid", 132'(out_valid), 132'd1);
                    chk("bp_hold", 132'(out_data), 132'(held));
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two transactions in flight.
        in_valid = 1'b1; in_feature = pack4(11, 22, 33, 44); in_scaler = 32'd5;
        in_shift = 6'd0; in_round = 1'b0; in_sat = 1'b1;
        @(posedge clk); #1;
        in_feature = pack4(55, 66, 77, 88);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 132'(out_valid), 132'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_idle", 132'(out_valid), 132'd0);
        end
        @(posedge clk); #1;
        one_shot("post_rst", pack4(7, -7, 1, 0), 32'd10, 6'd1, 1'b0, 1'b1, 1'b0,
                 pack4(35, -35, 5, 0), 4'b0000);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_feature = {rand_word(), rand_word(), rand_word(), rand_word()};
            in_scaler  = ($urandom_range(0, 1) != 0) ? rand_word() : 32'($urandom_range(0, 4096));
            in_shift   = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 12));
            in_round   = 1'($urandom_range(0, 1));
            in_sat     = 1'($urandom_range(0, 1));
            out_ready  = ($urandom_range(0, 3) != 0);
            ovf_clr    = ($urandom_range(0, 15) == 0);
            @(posedge clk); #1;
        end
        ovf_clr = 1'b0;
        drain();
        chk("final_queue_empty", 132'(exp_q.size()), 132'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "time limit");
    end

endmodule
